qlm_acc: RTL and testbench
==========================

QLM_ACC -- requirements
Module: qlm_acc

Interface
REQ-001 Parameter ACC_W, default 40, accumulator width in bits (>= 33).
REQ-002 Parameter LEN_W, default 8, term-counter width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 p_i  input  32  product from the upstream log multiplier, one's-complement signed.
REQ-006 p_sign_i  input  1  product sign, i.e. operand-sign XOR from the multiplier.
REQ-007 p_last_i  input  1  marks the final term of a frame.
REQ-008 p_valid_i  input  1  term valid.
REQ-009 p_ready_o  output  1  term accepted when p_valid_i and p_ready_o are both high.
REQ-010 acc_o  output  ACC_W  frame sum, two's complement.
REQ-011 cnt_o  output  LEN_W  number of terms in the frame, saturating at all-ones.
REQ-012 ovf_o  output  1  sticky overflow for the current frame.
REQ-013 acc_valid_o  output  1  result valid.
REQ-014 acc_ready_i  input  1  result consumed when acc_valid_o and acc_ready_i are both high.

Function
REQ-015 Each accepted term SHALL be term = sext(p_i) + cin, where cin = p_sign_i AND (p_i != 0); this converts one's complement to two's complement.
REQ-016 Case p_i = 0 with p_sign_i = 1 (multiplier zero-operand output) SHALL contribute exactly 0.
REQ-017 States SHALL be IDLE, ACC and HOLD.
REQ-018 IDLE: an accepted term SHALL load acc = term and cnt = 1, then go to HOLD if p_last_i, else to ACC.
REQ-019 ACC: an accepted term SHALL set acc = acc + term and cnt = cnt + 1 (saturating), then go to HOLD if p_last_i.
REQ-020 p_ready_o SHALL be 1 in IDLE and ACC and 0 in HOLD; no same-cycle pass-through.
REQ-021 acc_valid_o SHALL be 1 exactly in HOLD; acc_o, cnt_o and ovf_o SHALL be stable while in HOLD.
REQ-022 HOLD with acc_ready_i SHALL go to IDLE next cycle; otherwise the state holds indefinitely.
REQ-023 Result latency SHALL be 1 cycle from acceptance of the last term to acc_valid_o.
REQ-024 Sustained throughput SHALL be 1 term per cycle within a frame, plus at least one HOLD cycle per frame.
REQ-025 ovf_o SHALL be set on signed overflow of any add in the frame and cleared on the first term of the next frame.
REQ-026 A single-term frame (p_last_i on the first term) SHALL give acc = term and cnt = 1.

Reset
REQ-027 On rst the block SHALL enter IDLE with acc_o = 0, cnt_o = 0, ovf_o = 0, acc_valid_o = 0 and p_ready_o = 1 on the next cycle.
REQ-028 rst SHALL take priority over all handshakes; a partial frame SHALL be discarded.

Configuration
REQ-029 With QLM_ACC_SAT_EN defined, overflowing adds SHALL clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1) and set ovf_o.
REQ-030 Without QLM_ACC_SAT_EN, adds SHALL wrap modulo 2^ACC_W and still set ovf_o.

Structure
REQ-031 Package qlm_pkg SHALL hold ACC_W and LEN_W defaults and the state enum type.
REQ-032 Sub-module qlm_sat_add SHALL implement an ACC_W adder with carry-in, overflow detect and macro-controlled clamp.

Verification
REQ-033 p_i = 100, 200, 300, sign 0, last on 3rd -> acc_o = 600, cnt_o = 3, ovf_o = 0, acc_valid_o the cycle after the 3rd accept.
REQ-034 p_i = 32'hFFFF_FF9B with sign 1, then 50 with sign 0 and last -> acc_o = -50, cnt_o = 2.
REQ-035 p_i = 0 with sign 1, last -> acc_o = 0, cnt_o = 1.
REQ-036 ACC_W = 34, five terms of 32'h7FFF_FFFF -> with macro acc_o = 8589934591, ovf_o = 1; without macro acc_o = -6442450949, ovf_o = 1.
REQ-037 acc_ready_i low for 3 cycles in HOLD with p_valid_i high -> p_ready_o = 0, outputs stable, no term accepted; on release, IDLE next cycle, then the next term starts a new frame.
REQ-038 rst asserted after 2 of 4 terms -> IDLE with all outputs zero; a following 1-term frame with p_i = 7 gives acc_o = 7, cnt_o = 1.

Source files
------------

// File: rtl/qlm_pkg.sv
// qlm_pkg: shared defaults and state type for the log-multiplier accumulator.
package qlm_pkg;
    localparam int ACC_W_DEF = 40;
    localparam int LEN_W_DEF = 8;
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_e;
endpackage

// File: rtl/qlm_sat_add.sv
// qlm_sat_add: W-bit signed adder with carry-in and overflow flag.
// Clamps to the signed range when QLM_ACC_SAT_EN is defined, wraps otherwise.
module qlm_sat_add #(
    parameter int W = 40
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);
    logic [W:0] s;
    always_comb begin
        s = {a_i[W-1], a_i} + {b_i[W-1], b_i} + {{W{1'b0}}, cin_i};
        ovf_o = s[W] ^ s[W-1];
`ifdef QLM_ACC_SAT_EN
        // s[W] is the true sign of the unbounded result
        sum_o = ovf_o ? (s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : s[W-1:0];
`else
        sum_o = s[W-1:0];
`endif
    end
endmodule

// File: rtl/qlm_acc.sv
// qlm_acc: frame accumulator for one's-complement products from a log multiplier.
// Define QLM_ACC_SAT_EN to clamp overflowing adds instead of wrapping.
module qlm_acc
    import qlm_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      p_i,
    input  logic             p_sign_i,
    input  logic             p_last_i,
    input  logic             p_valid_i,
    output logic             p_ready_o,
    output logic [ACC_W-1:0] acc_o,
    output logic [LEN_W-1:0] cnt_o,
    output logic             ovf_o,
    output logic             acc_valid_o,
    input  logic             acc_ready_i
);
    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, add_ovf, idle, accept;

    assign idle        = state_q == IDLE;
    assign p_ready_o   = state_q != HOLD;
    assign acc_valid_o = state_q == HOLD;
    assign accept      = p_valid_i & p_ready_o;
    assign acc_o       = acc_q;
    assign cnt_o       = cnt_q;
    assign ovf_o       = ovf_q;

    // Adding zero on the first term turns the load into the same add path.
    qlm_sat_add #(.W(ACC_W)) u_add (
        .a_i   (idle ? '0 : acc_q),
        .b_i   ({{(ACC_W-32){p_i[31]}}, p_i}),
        .cin_i (p_sign_i & |p_i),
        .sum_o (sum),
        .ovf_o (add_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (accept) begin
            acc_d   = sum;
            cnt_d   = idle ? LEN_W'(1) : cnt_q + LEN_W'(~&cnt_q);
            ovf_d   = (!idle && ovf_q) || add_ovf;
            state_d = p_last_i ? HOLD : ACC;
        end else if (state_q == HOLD && acc_ready_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_qlm_acc.sv
// tb_qlm_acc: directed and randomized frames checked against an arithmetic model.
module tb_qlm_acc;
    localparam int ACC_W = 34;
    localparam int LEN_W = 4;
    localparam longint MAXV = (64'sd1 <<< (ACC_W-1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (ACC_W-1));
    localparam longint MODV = 64'sd1 <<< ACC_W;
    localparam int CNT_MAX = (1 << LEN_W) - 1;

    logic             clk = 0, rst = 1;
    logic [31:0]      p_i = 0;
    logic             p_sign_i = 0, p_last_i = 0, p_valid_i = 0, acc_ready_i = 0;
    logic             p_ready_o, ovf_o, acc_valid_o;
    logic [ACC_W-1:0] acc_o;
    logic [LEN_W-1:0] cnt_o;

    int     vectors = 0, miscompares = 0;
    longint acc_m = 0;
    int     cnt_m = 0;
    bit     ovf_m = 0, hold_m = 0, infr_m = 0;

    qlm_acc #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .p_i(p_i), .p_sign_i(p_sign_i), .p_last_i(p_last_i),
        .p_valid_i(p_valid_i), .p_ready_o(p_ready_o), .acc_o(acc_o), .cnt_o(cnt_o),
        .ovf_o(ovf_o), .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("ready", 64'(p_ready_o), 64'(!hold_m));
        chk("valid", 64'(acc_valid_o), 64'(hold_m));
        chk("acc", 64'(acc_o), 64'(acc_m[ACC_W-1:0]));
        chk("cnt", 64'(cnt_o), 64'(cnt_m));
        chk("ovf", 64'(ovf_o), 64'(ovf_m));
    endtask

    // Frame sum in plain integers; range excursion decides overflow.
    task automatic model_add(input logic [31:0] p, input bit s);
        longint t, sum;
        t = longint'($signed(p)) + ((s && p != 0) ? 1 : 0);
        sum = (infr_m ? acc_m : 0) + t;
        ovf_m = infr_m ? ovf_m : 0;
        cnt_m = infr_m ? (cnt_m < CNT_MAX ? cnt_m + 1 : CNT_MAX) : 1;
        if (sum > MAXV || sum < MINV) begin
            ovf_m = 1;
`ifdef QLM_ACC_SAT_EN
            sum = sum > MAXV ? MAXV : MINV;
`else
            sum = sum > MAXV ? sum - MODV : sum + MODV;
`endif
        end
        acc_m = sum;
    endtask

    task automatic cyc(input bit v, input logic [31:0] p, input bit s, input bit l, input bit r);
        p_valid_i = v; p_i = p; p_sign_i = s; p_last_i = l; acc_ready_i = r;
        chk_all();
        if (hold_m) begin
            if (r) begin hold_m = 0; infr_m = 0; end
        end else if (v) begin
            model_add(p, s);
            infr_m = !l;
            hold_m = l;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1; p_valid_i = 0; acc_ready_i = 0;
        @(posedge clk); #1;
        rst = 0;
        acc_m = 0; cnt_m = 0; ovf_m = 0; hold_m = 0; infr_m = 0;
        chk_all();
    endtask

    initial begin
        logic [31:0] p;
        @(posedge clk); #1;
        do_reset();
        chk("rst_acc", 64'(acc_o), 64'd0);
        chk("rst_ready", 64'(p_ready_o), 64'd1);

        cyc(1, 100, 0, 0, 0); cyc(1, 200, 0, 0, 0); cyc(1, 300, 0, 1, 0);
        chk("r033_valid", 64'(acc_valid_o), 64'd1);
        chk("r033_acc", 64'(acc_o), 64'd600);
        chk("r033_cnt", 64'(cnt_o), 64'd3);
        cyc(0, 0, 0, 0, 1);

        cyc(1, 32'hFFFF_FF9B, 1, 0, 0); cyc(1, 50, 0, 1, 0);
        chk("r034_acc", 64'(acc_o), 64'h3_FFFF_FFCE);
        chk("r034_cnt", 64'(cnt_o), 64'd2);
        cyc(0, 0, 0, 0, 1);

        cyc(1, 0, 1, 1, 0);
        chk("r035_acc", 64'(acc_o), 64'd0);
        chk("r035_cnt", 64'(cnt_o), 64'd1);
        cyc(0, 0, 0, 0, 1);

        for (int i = 0; i < 5; i++) cyc(1, 32'h7FFF_FFFF, 0, i == 4, 0);
`ifdef QLM_ACC_SAT_EN
        chk("r036_acc", 64'(acc_o), 64'h1_FFFF_FFFF);
`else
        chk("r036_acc", 64'(acc_o), 64'h2_7FFF_FFFB);
`endif
        chk("r036_ovf", 64'(ovf_o), 64'd1);
        for (int i = 0; i < 3; i++) cyc(1, 5, 0, 1, 0);
        chk("r037_ready", 64'(p_ready_o), 64'd0);
        cyc(1, 5, 0, 0, 1);
        chk("r037_idle", 64'(acc_valid_o), 64'd0);
        cyc(1, 9, 0, 1, 0);
        chk("r037_acc", 64'(acc_o), 64'd9);
        chk("r037_ovf", 64'(ovf_o), 64'd0);
        cyc(0, 0, 0, 0, 1);

        cyc(1, 11, 0, 0, 0); cyc(1, 22, 1, 0, 0);
        do_reset();
        cyc(1, 7, 0, 1, 0);
        chk("r038_acc", 64'(acc_o), 64'd7);
        chk("r038_cnt", 64'(cnt_o), 64'd1);
        cyc(0, 0, 0, 0, 1);

        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(1, 20);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) cyc(0, $urandom, 1, 1, 1);
                case ($urandom_range(0, 4))
                    0: p = 32'h7FFF_FFFF;
                    1: p = 32'h8000_0000;
                    2: p = 32'd0;
                    3: p = $urandom_range(0, 1000);
                    default: p = $urandom;
                endcase
                cyc(1, p, $urandom_range(0, 1) == 1, k == len - 1, 0);
            end
            for (int h = $urandom_range(0, 3); h > 0; h--) cyc($urandom_range(0, 1) == 1, $urandom, 0, 0, 0);
            cyc($urandom_range(0, 1) == 1, 3, 0, 0, 1);
        end
        chk_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
